// File: rtl/dual_rail_frame_rx_pkg.sv
// Shared frame definitions for the dual-rail frame receiver: frame length,
// header values, payload bit positions and handshake state encodings.
package dual_rail_frame_rx_pkg;

    localparam int unsigned FRAME_LEN = 5;
    localparam int unsigned BIT_CNT_W = $clog2(FRAME_LEN);

    // Expected header bit values, in arrival order.
    localparam logic HDR_B0 = 1'b1;
    localparam logic HDR_B1 = 1'b0;

    // Bit positions within a frame (arrival order, b0 first).
    localparam logic [BIT_CNT_W-1:0] HDR0_POS = 3'd0;
    localparam logic [BIT_CNT_W-1:0] HDR1_POS = 3'd1;
    localparam logic [BIT_CNT_W-1:0] CH_POS   = 3'd2;
    localparam logic [BIT_CNT_W-1:0] DIR_POS  = 3'd3;
    localparam logic [BIT_CNT_W-1:0] PAR_POS  = 3'd4;

    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_ACK   = 2'd1,
        HS_DRAIN = 2'd2
    } hs_state_e;

    // Even parity over the payload: the parity bit must equal ch ^ dir.
    function automatic logic frame_parity(input logic ch, input logic dir);
        return ch ^ dir;
    endfunction

endpackage

// File: rtl/rail_sync.sv
// Two-flop synchronizer for the asynchronous dual-rail inputs.
module rail_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rail0,
    input  logic i_rail1,
    output logic o_s0,
    output logic o_s1
);

    logic [1:0] r_meta;
    logic [1:0] r_sync;

    // Both rails go through two flop stages; only r_sync is used downstream.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= {i_rail1, i_rail0};
            r_sync <= r_meta;
        end
    end

    assign o_s0 = r_sync[0];
    assign o_s1 = r_sync[1];

endmodule

// File: rtl/dual_rail_frame_rx.sv
// Dual-rail four-phase frame receiver: synchronizes the rails, acknowledges
// each bit, assembles 5-bit command frames and tracks per-channel levels.
module dual_rail_frame_rx #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit0_in,
    input  logic             bit1_in,
    output logic             ack,
    output logic             ch1_up,
    output logic             ch1_down,
    output logic             ch2_up,
    output logic             ch2_down,
    output logic             frame_err,
    output logic [CNT_W-1:0] level_ch1,
    output logic [CNT_W-1:0] level_ch2
);

    import dual_rail_frame_rx_pkg::*;

    logic w_s0;
    logic w_s1;
    logic w_bit;
    logic w_capture;

    hs_state_e              r_state,      w_state_nxt;
    logic                   r_ack,        w_ack_nxt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt,    w_bit_cnt_nxt;
    // Only the payload bits are kept; header and parity are checked on arrival.
    logic [DIR_POS:CH_POS]  r_shift,      w_shift_nxt;
    logic [TO_W-1:0]        r_to_cnt,     w_to_cnt_nxt;
    logic                   r_ch1_up,     w_ch1_up_nxt;
    logic                   r_ch1_down,   w_ch1_down_nxt;
    logic                   r_ch2_up,     w_ch2_up_nxt;
    logic                   r_ch2_down,   w_ch2_down_nxt;
    logic                   r_frame_err,  w_frame_err_nxt;
    logic [CNT_W-1:0]       r_level_ch1,  w_level_ch1_nxt;
    logic [CNT_W-1:0]       r_level_ch2,  w_level_ch2_nxt;

    rail_sync u_rail_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_rail0 (bit0_in),
        .i_rail1 (bit1_in),
        .o_s0    (w_s0),
        .o_s1    (w_s1)
    );

    // A captured bit is 1 when the "1" rail is the one that rose.
    assign w_bit = w_s1;

    // State register for the handshake FSM, frame assembly and level counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= HS_IDLE;
            r_ack       <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_ch1_up    <= 1'b0;
            r_ch1_down  <= 1'b0;
            r_ch2_up    <= 1'b0;
            r_ch2_down  <= 1'b0;
            r_frame_err <= 1'b0;
            r_level_ch1 <= '0;
            r_level_ch2 <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_ack_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_ch1_up    <= w_ch1_up_nxt;
            r_ch1_down  <= w_ch1_down_nxt;
            r_ch2_up    <= w_ch2_up_nxt;
            r_ch2_down  <= w_ch2_down_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_level_ch1 <= w_level_ch1_nxt;
            r_level_ch2 <= w_level_ch2_nxt;
        end
    end

    // Next-state: handshake FSM, inter-bit timeout and frame decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_ack_nxt       = r_ack;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_to_cnt_nxt    = r_to_cnt;
        w_ch1_up_nxt    = 1'b0;
        w_ch1_down_nxt  = 1'b0;
        w_ch2_up_nxt    = 1'b0;
        w_ch2_down_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_level_ch1_nxt = r_level_ch1;
        w_level_ch2_nxt = r_level_ch2;
        w_capture       = 1'b0;

        unique case (r_state)
            HS_IDLE: begin
                if (w_s0 && w_s1) begin
                    // Both rails high is not a legal code: drop the frame, withhold ack.
                    w_frame_err_nxt = 1'b1;
                    w_bit_cnt_nxt   = '0;
                    w_to_cnt_nxt    = '0;
                    w_state_nxt     = HS_DRAIN;
                end else if (w_s0 || w_s1) begin
                    w_capture    = 1'b1;
                    w_ack_nxt    = 1'b1;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = HS_ACK;
                end else if (r_bit_cnt != '0) begin
                    // Idle inside a frame: abort once the gap reaches TIMEOUT cycles.
                    if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        w_frame_err_nxt = 1'b1;
                        w_bit_cnt_nxt   = '0;
                        w_to_cnt_nxt    = '0;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end else begin
                    w_to_cnt_nxt = '0;
                end
            end
            HS_ACK: begin
                w_to_cnt_nxt = '0;
                if (!w_s0 && !w_s1) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = HS_IDLE;
                end
            end
            HS_DRAIN: begin
                w_to_cnt_nxt = '0;
                if (!w_s0 && !w_s1) begin
                    w_state_nxt = HS_IDLE;
                end
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = HS_IDLE;
            end
        endcase

        if (w_capture) begin
            case (r_bit_cnt)
                HDR0_POS: begin
                    if (w_bit != HDR_B0) begin
                        w_frame_err_nxt = 1'b1;
                        w_bit_cnt_nxt   = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                HDR1_POS: begin
                    if (w_bit != HDR_B1) begin
                        w_frame_err_nxt = 1'b1;
                        w_bit_cnt_nxt   = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                CH_POS, DIR_POS: begin
                    w_shift_nxt[r_bit_cnt] = w_bit;
                    w_bit_cnt_nxt          = r_bit_cnt + 1'b1;
                end
                PAR_POS: begin
                    w_bit_cnt_nxt = '0;
                    if (w_bit != frame_parity(r_shift[CH_POS], r_shift[DIR_POS])) begin
                        w_frame_err_nxt = 1'b1;
                    end else if (!r_shift[CH_POS]) begin
                        if (r_shift[DIR_POS]) begin
                            w_ch1_up_nxt = 1'b1;
                            if (r_level_ch1 != '1) w_level_ch1_nxt = r_level_ch1 + CNT_W'(1);
                        end else begin
                            w_ch1_down_nxt = 1'b1;
                            if (r_level_ch1 != '0) w_level_ch1_nxt = r_level_ch1 - CNT_W'(1);
                        end
                    end else begin
                        if (r_shift[DIR_POS]) begin
                            w_ch2_up_nxt = 1'b1;
                            if (r_level_ch2 != '1) w_level_ch2_nxt = r_level_ch2 + CNT_W'(1);
                        end else begin
                            w_ch2_down_nxt = 1'b1;
                            if (r_level_ch2 != '0) w_level_ch2_nxt = r_level_ch2 - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign ch1_up    = r_ch1_up;
    assign ch1_down  = r_ch1_down;
    assign ch2_up    = r_ch2_up;
    assign ch2_down  = r_ch2_down;
    assign frame_err = r_frame_err;
    assign level_ch1 = r_level_ch1;
    assign level_ch2 = r_level_ch2;

endmodule

// File: tb/tb_dual_rail_frame_rx.sv
// Directed bench for dual_rail_frame_rx: four-phase senders, pulse counting
// monitor and per-scenario tasks with hand-computed expectations.
module tb_dual_rail_frame_rx;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             bit0_in = 1'b0;
    logic             bit1_in = 1'b0;
    logic             ack;
    logic             ch1_up;
    logic             ch1_down;
    logic             ch2_up;
    logic             ch2_down;
    logic             frame_err;
    logic [CNT_W-1:0] level_ch1;
    logic [CNT_W-1:0] level_ch2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Monitor counters: cycles each pulse is high, ack rising edges, overlaps.
    int n_c1u = 0, n_c1d = 0, n_c2u = 0, n_c2d = 0, n_err = 0, n_ack_rise = 0, n_overlap = 0;
    logic prev_ack = 1'b0;

    dual_rail_frame_rx #(
        .CNT_W   (CNT_W),
        .TIMEOUT (1024),
        .TO_W    (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit0_in   (bit0_in),
        .bit1_in   (bit1_in),
        .ack       (ack),
        .ch1_up    (ch1_up),
        .ch1_down  (ch1_down),
        .ch2_up    (ch2_up),
        .ch2_down  (ch2_down),
        .frame_err (frame_err),
        .level_ch1 (level_ch1),
        .level_ch2 (level_ch2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ch1_up)    n_c1u++;
        if (ch1_down)  n_c1d++;
        if (ch2_up)    n_c2u++;
        if (ch2_down)  n_c2d++;
        if (frame_err) n_err++;
        if (ack && !prev_ack) n_ack_rise++;
        prev_ack = ack;
        if ((32'(ch1_up) + 32'(ch1_down) + 32'(ch2_up) + 32'(ch2_down) + 32'(frame_err)) > 1)
            n_overlap++;
    end

    task automatic wait_ack(input logic v);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ack === v) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_ack: ack never reached %0b (still %0b)", v, ack);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        if (b) bit1_in = 1'b1;
        else   bit0_in = 1'b1;
        wait_ack(1'b1);
        @(negedge clk);
        bit0_in = 1'b0;
        bit1_in = 1'b0;
        wait_ack(1'b0);
    endtask

    // f[4] is the first bit on the wire (b0), f[0] the parity bit.
    task automatic send_frame(input logic [4:0] f);
        for (int i = 4; i >= 0; i--) send_bit(f[i]);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ack, ch1_up, ch1_down, ch2_up, ch2_down, frame_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {ack, ch1_up, ch1_down, ch2_up, ch2_down, frame_err});
        end
        n_cmp++;
        if (level_ch1 !== 8'd0 || level_ch2 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_levels: got %0d/%0d want 0/0", level_ch1, level_ch2);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ch1_up();
        logic [2:0] lat;
        int s_c1u = n_c1u, s_oth = n_c1d + n_c2u + n_c2d, s_err = n_err, s_ack = n_ack_rise;
        // First bit by hand to check rise/fall latency of ack.
        @(negedge clk);
        bit1_in = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            @(posedge clk);
            #1;
            lat[i] = ack;
        end
        n_cmp++;
        if (lat !== 3'b001) begin
            n_fail++;
            $display("FAIL ack_rise_latency: got %b want 001", lat);
        end
        @(negedge clk);
        bit1_in = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            @(posedge clk);
            #1;
            lat[i] = ack;
        end
        n_cmp++;
        if (lat !== 3'b110) begin
            n_fail++;
            $display("FAIL ack_fall_latency: got %b want 110", lat);
        end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_c1u - s_c1u !== 1 || n_c1d + n_c2u + n_c2d - s_oth !== 0) begin
            n_fail++;
            $display("FAIL ch1_up_pulse: ch1_up cycles %0d other %0d want 1/0",
                     n_c1u - s_c1u, n_c1d + n_c2u + n_c2d - s_oth);
        end
        n_cmp++;
        if (level_ch1 !== 8'd1 || n_err != s_err) begin
            n_fail++;
            $display("FAIL ch1_up_level: level %0d errs %0d want 1/0", level_ch1, n_err - s_err);
        end
        n_cmp++;
        if (n_ack_rise - s_ack !== 5) begin
            n_fail++;
            $display("FAIL ch1_up_acks: got %0d want 5", n_ack_rise - s_ack);
        end
    endtask

    task automatic test_ch2_sat();
        int s_c2d = n_c2d, s_c2u = n_c2u;
        send_frame(5'b10101);
        n_cmp++;
        if (n_c2d - s_c2d !== 1 || level_ch2 !== 8'd0) begin
            n_fail++;
            $display("FAIL ch2_down_floor: pulses %0d level %0d want 1/0", n_c2d - s_c2d, level_ch2);
        end
        repeat (3) send_frame(5'b10110);
        n_cmp++;
        if (n_c2u - s_c2u !== 3 || level_ch2 !== 8'd3) begin
            n_fail++;
            $display("FAIL ch2_up_x3: pulses %0d level %0d want 3/3", n_c2u - s_c2u, level_ch2);
        end
    endtask

    task automatic test_bad_parity();
        int s_err = n_err, s_cmd = n_c1u + n_c1d + n_c2u + n_c2d;
        send_frame(5'b10010);
        n_cmp++;
        if (n_err - s_err !== 1 || n_c1u + n_c1d + n_c2u + n_c2d - s_cmd !== 0) begin
            n_fail++;
            $display("FAIL bad_parity: errs %0d cmds %0d want 1/0",
                     n_err - s_err, n_c1u + n_c1d + n_c2u + n_c2d - s_cmd);
        end
        n_cmp++;
        if (level_ch1 !== 8'd1 || level_ch2 !== 8'd3) begin
            n_fail++;
            $display("FAIL bad_parity_levels: got %0d/%0d want 1/3", level_ch1, level_ch2);
        end
        send_frame(5'b10011);
        n_cmp++;
        if (level_ch1 !== 8'd2 || n_err - s_err !== 1) begin
            n_fail++;
            $display("FAIL after_parity_frame: level %0d errs %0d want 2/1", level_ch1, n_err - s_err);
        end
    endtask

    task automatic test_header_err();
        int s_err = n_err, s_c1d = n_c1d;
        send_bit(1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_err - s_err !== 1) begin
            n_fail++;
            $display("FAIL header_err: errs %0d want 1", n_err - s_err);
        end
        send_frame(5'b10000);
        n_cmp++;
        if (n_c1d - s_c1d !== 1 || level_ch1 !== 8'd1) begin
            n_fail++;
            $display("FAIL after_header_frame: pulses %0d level %0d want 1/1", n_c1d - s_c1d, level_ch1);
        end
    endtask

    task automatic test_illegal();
        int s_err, s_c1d = n_c1d;
        send_bit(1'b1);
        send_bit(1'b0);
        s_err = n_err;
        @(negedge clk);
        bit0_in = 1'b1;
        bit1_in = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0 || n_err - s_err !== 1) begin
            n_fail++;
            $display("FAIL illegal_code: ack %0b errs %0d want 0/1", ack, n_err - s_err);
        end
        bit0_in = 1'b0;
        bit1_in = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0 || n_err - s_err !== 1) begin
            n_fail++;
            $display("FAIL illegal_drain: ack %0b errs %0d want 0/1", ack, n_err - s_err);
        end
        send_frame(5'b10000);
        n_cmp++;
        if (n_c1d - s_c1d !== 1 || level_ch1 !== 8'd0) begin
            n_fail++;
            $display("FAIL after_illegal_frame: pulses %0d level %0d want 1/0", n_c1d - s_c1d, level_ch1);
        end
    endtask

    task automatic test_timeout();
        int waited = 0;
        int s_c2u = n_c2u;
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 1; i <= 1200 && waited == 0; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) waited = i;
        end
        n_cmp++;
        if (waited !== 1024) begin
            n_fail++;
            $display("FAIL timeout_cycles: err after %0d idle cycles want 1024", waited);
        end
        repeat (2) @(negedge clk);
        send_frame(5'b10110);
        n_cmp++;
        if (n_c2u - s_c2u !== 1 || level_ch2 !== 8'd4) begin
            n_fail++;
            $display("FAIL after_timeout_frame: pulses %0d level %0d want 1/4", n_c2u - s_c2u, level_ch2);
        end
    endtask

    task automatic test_reset_mid();
        int s_cmd, s_err;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        bit1_in = 1'b1;
        wait_ack(1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ack, ch1_up, ch1_down, ch2_up, ch2_down, frame_err} !== 6'b0 ||
            level_ch1 !== 8'd0 || level_ch2 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid: flags %b levels %0d/%0d want 000000 0/0",
                     {ack, ch1_up, ch1_down, ch2_up, ch2_down, frame_err}, level_ch1, level_ch2);
        end
        @(negedge clk);
        reset = 1'b1;
        bit1_in = 1'b0;
        s_cmd = n_c1u + n_c1d + n_c2u + n_c2d;
        s_err = n_err;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0 || n_c1u + n_c1d + n_c2u + n_c2d - s_cmd !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: ack %0b cmds %0d want 0/0",
                     ack, n_c1u + n_c1d + n_c2u + n_c2d - s_cmd);
        end
        send_frame(5'b10011);
        n_cmp++;
        if (level_ch1 !== 8'd1 || n_err - s_err !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_fresh_frame: level %0d errs %0d want 1/0",
                     level_ch1, n_err - s_err);
        end
    endtask

    initial begin
        test_reset();
        test_ch1_up();
        test_ch2_sat();
        test_bad_parity();
        test_header_err();
        test_illegal();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (n_overlap !== 0) begin
            n_fail++;
            $display("FAIL pulse_exclusive: %0d overlapping cycles want 0", n_overlap);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
